mem_rsp_pipe: RTL and testbench

- Parametrised, multi-channel memory request/response adapter between core fetch/LSU ports and a combinational-read simulation memory.
- Replaces fixed one-cycle read-data registering with:
  - a configurable read latency LAT;
  - valid/ready handshakes on the request and response sides;
  - a per-channel response FIFO with credit-based request throttling, so the core can stall response acceptance without losing data.
- Channel 0 = instruction fetch, channel 1 = data; channels are fully independent.

---
 rtl/mem_rsp_pipe_pkg.sv | 15 +
 rtl/mem_rsp_pipe_rsp_fifo.sv | 98 +++++++++
 rtl/mem_rsp_pipe.sv | 126 ++++++++++++
 tb/tb_mem_rsp_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rsp_pipe_pkg.sv
// Shared constants and parameter checks for the memory request/response adapter.
package mem_rsp_pipe_pkg;

    localparam int CH_INST    = 0;
    localparam int CH_DATA    = 1;
    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 64;
    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 4;

    function automatic bit lat_is_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_rsp_pipe_rsp_fifo.sv
// Response FIFO: storage ring plus a registered head; an empty FIFO loads a push
// straight into the head register, so data is visible the cycle after the push.
module rsp_fifo
    import mem_rsp_pipe_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] pop_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          load_s, store_s, take_s;

    // Head refill, storage write and occupancy bookkeeping.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        store_s  = push;
        take_s   = 1'b0;
        load_s   = !valid_q || pop;
        if (load_s) begin
            if (cnt_q != {CW{1'b0}}) begin
                dout_d  = mem_q[rd_ptr_q];
                valid_d = 1'b1;
                take_s  = 1'b1;
            end else if (push) begin
                dout_d  = push_data;
                valid_d = 1'b1;
                store_s = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
        if (take_s) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (store_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({store_s, take_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; contents are discarded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            dout_q   <= {DW{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = !valid_q;
    assign pop_data = dout_q;

endmodule

// File: rtl/mem_rsp_pipe.sv
// Multi-channel request/response adapter: per channel a read-latency pipe, a
// response FIFO and a credit counter that throttles requests to FIFO capacity.
module mem_rsp_pipe
    import mem_rsp_pipe_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = DEFAULT_DW,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        req_valid,
    output logic [NCH-1:0]        req_ready,
    input  logic [NCH*DW/8-1:0]   req_wen,
    input  logic [NCH*AW-1:0]     req_addr,
    input  logic [NCH*DW-1:0]     req_wdata,
    output logic [NCH-1:0]        mem_en,
    output logic [NCH*DW/8-1:0]   mem_wen,
    output logic [NCH*AW-1:0]     mem_addr,
    output logic [NCH*DW-1:0]     mem_wdata,
    input  logic [NCH*DW-1:0]     mem_rdata,
    output logic [NCH-1:0]        rsp_valid,
    input  logic [NCH-1:0]        rsp_ready,
    output logic [NCH*DW-1:0]     rsp_rdata
);

    localparam int SW = DW / 8;
    localparam int CW = $clog2(DEPTH) + 1;

    if (!lat_is_legal(LAT)) begin : g_lat_check
        $error("mem_rsp_pipe: LAT=%0d outside legal range %0d..%0d", LAT, LAT_MIN, LAT_MAX);
    end

    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0] out_q, out_d;
        logic          acc_s, rd_acc_s, pop_s, push_s;
        logic          fifo_full_s, fifo_empty_s;
        logic [DW-1:0] push_data_s;

        assign acc_s          = req_valid[c] & req_ready[c];
        assign rd_acc_s       = acc_s & (req_wen[c*SW +: SW] == {SW{1'b0}});
        assign pop_s          = rsp_valid[c] & rsp_ready[c];
        // A full storage ring implies exhausted credits; the extra term is a guard only.
        assign req_ready[c]   = !reset & (out_q < CW'(DEPTH)) & !fifo_full_s;
        assign mem_en[c]      = acc_s;
        assign mem_wen[c*SW +: SW] = acc_s ? req_wen[c*SW +: SW] : {SW{1'b0}};
        assign rsp_valid[c]   = !fifo_empty_s;

        // Credits track reads in the pipe plus FIFO occupancy.
        always_comb begin
            out_d = out_q;
            case ({rd_acc_s, pop_s})
                2'b10:   out_d = out_q + CW'(1);
                2'b01:   out_d = out_q - CW'(1);
                default: out_d = out_q;
            endcase
        end

        // Credit register.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_q <= {CW{1'b0}};
            end else begin
                out_q <= out_d;
            end
        end

        if (LAT == 1) begin : g_pipe_none
            assign push_s      = rd_acc_s;
            assign push_data_s = mem_rdata[c*DW +: DW];
        end else begin : g_pipe
            localparam int NS = LAT - 1;
            logic [NS-1:0] v_q, v_d;
            logic [DW-1:0] d_q [NS];
            logic [DW-1:0] d_d [NS];

            // Shift read valid and sampled read data down the latency pipe.
            always_comb begin
                v_d    = v_q;
                d_d    = d_q;
                v_d[0] = rd_acc_s;
                d_d[0] = mem_rdata[c*DW +: DW];
                for (int i = 1; i < NS; i++) begin
                    v_d[i] = v_q[i-1];
                    d_d[i] = d_q[i-1];
                end
            end

            // Pipe registers; in-flight reads are dropped on reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= {NS{1'b0}};
                    for (int i = 0; i < NS; i++) begin
                        d_q[i] <= {DW{1'b0}};
                    end
                end else begin
                    v_q <= v_d;
                    d_q <= d_d;
                end
            end

            assign push_s      = v_q[NS-1];
            assign push_data_s = d_q[NS-1];
        end

        rsp_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_rsp_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push_s),
            .push_data (push_data_s),
            .pop       (pop_s),
            .full      (fifo_full_s),
            .empty     (fifo_empty_s),
            .pop_data  (rsp_rdata[c*DW +: DW])
        );
    end

endmodule

// File: tb/tb_mem_rsp_pipe.sv
// Directed bench for mem_rsp_pipe: three instances with LAT=1,2,3 (DEPTH=4).
module tb_mem_rsp_pipe;
    import mem_rsp_pipe_pkg::*;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int NI  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NCH-1:0]      req_valid [NI];
    logic [NCH-1:0]      req_ready [NI];
    logic [NCH*SW-1:0]   req_wen   [NI];
    logic [NCH*AW-1:0]   req_addr  [NI];
    logic [NCH*DW-1:0]   req_wdata [NI];
    logic [NCH-1:0]      mem_en    [NI];
    logic [NCH*SW-1:0]   mem_wen   [NI];
    logic [NCH*AW-1:0]   mem_addr  [NI];
    logic [NCH*DW-1:0]   mem_wdata [NI];
    logic [NCH*DW-1:0]   mem_rdata [NI];
    logic [NCH-1:0]      rsp_valid [NI];
    logic [NCH-1:0]      rsp_ready [NI];
    logic [NCH*DW-1:0]   rsp_rdata [NI];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        mem_rsp_pipe #(
            .NCH(NCH), .AW(AW), .DW(DW), .LAT(k + 1), .DEPTH(4)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[k]),
            .req_ready (req_ready[k]),
            .req_wen   (req_wen[k]),
            .req_addr  (req_addr[k]),
            .req_wdata (req_wdata[k]),
            .mem_en    (mem_en[k]),
            .mem_wen   (mem_wen[k]),
            .mem_addr  (mem_addr[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_rdata (mem_rdata[k]),
            .rsp_valid (rsp_valid[k]),
            .rsp_ready (rsp_ready[k]),
            .rsp_rdata (rsp_rdata[k])
        );
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = '0;
            req_wen[k]   = '0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            mem_rdata[k] = '0;
            rsp_ready[k] = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wen_t [5];
        logic       vld_t [5];
        logic [63:0] dat_t [5];
        logic       erv_t [5];
        logic [63:0] erd_t [5];
        int idx;
        int got;

        // ---------------- reset state ----------------
        clear_inputs();
        reset = 1'b1;
        for (int k = 0; k < NI; k++) req_valid[k] = 2'b11;
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            check_eq("rst_req_ready", req_ready[k], 2'b00);
            check_eq("rst_mem_en",    mem_en[k],    2'b00);
            check_eq("rst_rsp_valid", rsp_valid[k], 2'b00);
            check_eq("rst_rsp_rdata", rsp_rdata[k], 128'h0);
        end
        clear_inputs();
        reset = 1'b0;
        tick();

        // ---------------- LAT=1 single read on ch0 ----------------
        rsp_ready[0] = 2'b11;
        req_valid[0] = 2'b01;
        req_addr[0][CH_INST*AW +: AW] = 32'h8000_0000;
        mem_rdata[0][CH_INST*DW +: DW] = 64'h0000_0000_0000_0013;
        #1;
        check_eq("l1_req_ready", req_ready[0], 2'b11);
        check_eq("l1_mem_en", mem_en[0], 2'b01);
        check_eq("l1_mem_addr", mem_addr[0][CH_INST*AW +: AW], 32'h8000_0000);
        tick();
        req_valid[0] = 2'b00;
        mem_rdata[0] = '0;
        #1;
        check_eq("l1_rsp_valid", rsp_valid[0], 2'b01);
        check_eq("l1_rsp_rdata", rsp_rdata[0][CH_INST*DW +: DW], 64'h13);
        tick();
        check_eq("l1_rsp_gone", rsp_valid[0], 2'b00);
        check_eq("l1_rdata_held", rsp_rdata[0][CH_INST*DW +: DW], 64'h13);

        // ---------------- LAT=1 write interleaved with reads on ch1 ----------------
        wen_t = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
        vld_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        dat_t = '{64'hA1, 64'h0, 64'hA2, 64'h0, 64'h0};
        erv_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        erd_t = '{64'h0, 64'hA1, 64'h0, 64'hA2, 64'h0};
        for (int i = 0; i < 5; i++) begin
            req_valid[0][CH_DATA] = vld_t[i];
            req_wen[0][CH_DATA*SW +: SW] = wen_t[i];
            req_wdata[0][CH_DATA*DW +: DW] = 64'h0000_0000_DEAD_BEEF;
            mem_rdata[0][CH_DATA*DW +: DW] = dat_t[i];
            #1;
            check_eq("wr_mem_wen", mem_wen[0], {(vld_t[i] ? wen_t[i] : 8'h00), 8'h00});
            check_eq("wr_req_ready", req_ready[0], 2'b11);
            if (i == 1) check_eq("wr_mem_wdata", mem_wdata[0][CH_DATA*DW +: DW], 64'hDEAD_BEEF);
            check_eq("wr_rsp_valid", rsp_valid[0][CH_DATA], erv_t[i]);
            if (erv_t[i]) check_eq("wr_rsp_rdata", rsp_rdata[0][CH_DATA*DW +: DW], erd_t[i]);
            tick();
        end
        clear_inputs();
        tick();

        // ---------------- LAT=3 eight back-to-back reads on ch0 ----------------
        rsp_ready[2] = 2'b01;
        for (int c = 0; c < 12; c++) begin
            req_valid[2][CH_INST] = (c < 8);
            mem_rdata[2][CH_INST*DW +: DW] = 64'(c + 1);
            #1;
            if (c < 8) check_eq("l3_req_ready", req_ready[2][CH_INST], 1'b1);
            check_eq("l3_rsp_valid", rsp_valid[2][CH_INST], (c >= 3 && c < 11));
            if (c >= 3 && c < 11) check_eq("l3_rsp_rdata", rsp_rdata[2][CH_INST*DW +: DW], 64'(c - 2));
            tick();
        end
        clear_inputs();
        tick();

        // ---------------- LAT=2 backpressure on ch0 ----------------
        // Two posted writes first: they must not consume credits.
        for (int c = 0; c < 2; c++) begin
            req_valid[1][CH_INST] = 1'b1;
            req_wen[1][CH_INST*SW +: SW] = 8'hFF;
            #1;
            check_eq("bp_wr_ready", req_ready[1][CH_INST], 1'b1);
            tick();
        end
        req_wen[1] = '0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid[1][CH_INST] = 1'b1;
            mem_rdata[1][CH_INST*DW +: DW] = 64'(16 + idx);
            #1;
            check_eq("bp_req_ready", req_ready[1][CH_INST], (c < 4));
            if (req_ready[1][CH_INST]) idx++;
            tick();
        end
        check_eq("bp_accepted", idx, 4);
        got = 0;
        rsp_ready[1][CH_INST] = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            req_valid[1][CH_INST] = (idx < 6);
            mem_rdata[1][CH_INST*DW +: DW] = 64'(16 + idx);
            #1;
            if (rsp_valid[1][CH_INST]) begin
                check_eq("bp_rsp_order", rsp_rdata[1][CH_INST*DW +: DW], 64'(16 + got));
                got++;
            end
            if (req_valid[1][CH_INST] && req_ready[1][CH_INST]) idx++;
            tick();
        end
        check_eq("bp_rsp_count", got, 6);
        check_eq("bp_req_count", idx, 6);
        clear_inputs();
        tick();

        // ---------------- LAT=2 accept+pop at out=DEPTH-1 on ch1 ----------------
        for (int c = 0; c < 3; c++) begin
            req_valid[1][CH_DATA] = 1'b1;
            mem_rdata[1][CH_DATA*DW +: DW] = 64'(33 + c);
            tick();
        end
        mem_rdata[1][CH_DATA*DW +: DW] = 64'd36;
        rsp_ready[1][CH_DATA] = 1'b1;
        #1;
        check_eq("sim_ready", req_ready[1][CH_DATA], 1'b1);
        check_eq("sim_rsp_valid", rsp_valid[1][CH_DATA], 1'b1);
        check_eq("sim_rsp_rdata", rsp_rdata[1][CH_DATA*DW +: DW], 64'd33);
        tick();
        rsp_ready[1][CH_DATA] = 1'b0;
        mem_rdata[1][CH_DATA*DW +: DW] = 64'd37;
        #1;
        check_eq("sim_ready_after", req_ready[1][CH_DATA], 1'b1);
        tick();
        req_valid[1][CH_DATA] = 1'b0;
        #1;
        check_eq("sim_full", req_ready[1][CH_DATA], 1'b0);
        rsp_ready[1][CH_DATA] = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (rsp_valid[1][CH_DATA]) begin
                check_eq("sim_drain_order", rsp_rdata[1][CH_DATA*DW +: DW], 64'(34 + got));
                got++;
            end
            tick();
        end
        check_eq("sim_drain_count", got, 4);
        clear_inputs();
        tick();

        // ---------------- LAT=3 reset with three reads in flight ----------------
        rsp_ready[2] = 2'b01;
        for (int c = 0; c < 3; c++) begin
            req_valid[2][CH_INST] = 1'b1;
            mem_rdata[2][CH_INST*DW +: DW] = 64'(49 + c);
            tick();
        end
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ready", req_ready[2], 2'b00);
        check_eq("mid_rst_mem_en", mem_en[2], 2'b00);
        tick();
        check_eq("mid_rst_rsp_valid", rsp_valid[2], 2'b00);
        check_eq("mid_rst_rdata", rsp_rdata[2][CH_INST*DW +: DW], 64'h0);
        reset = 1'b0;
        req_valid[2] = 2'b00;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_eq("post_rst_no_stale", rsp_valid[2], 2'b00);
        end
        rsp_ready[2] = 2'b00;
        for (int c = 0; c < 5; c++) begin
            req_valid[2][CH_INST] = 1'b1;
            #1;
            check_eq("post_rst_credit", req_ready[2][CH_INST], (c < 4));
            tick();
        end
        clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
